// File: rtl/truth_table_sweeper_if.sv
// Purpose : bundles the controller-facing and cell-facing signals of truth_table_sweeper.
// Signals : start (request sweep), busy, done (1-cycle pulse), in1/in2/in3 (cell drive),
//           out (cell response), signature[7:0], match, unstable.
// Modports: slave  - the sweeper itself.
//           master - controller plus cell under test.
interface truth_table_sweeper_if;
  logic       start;
  logic       busy;
  logic       done;
  logic       in1;
  logic       in2;
  logic       in3;
  logic       out;
  logic [7:0] signature;
  logic       match;
  logic       unstable;

  modport master (
    output start, out,
    input  busy, done, in1, in2, in3, signature, match, unstable
  );

  modport slave (
    input  start, out,
    output busy, done, in1, in2, in3, signature, match, unstable
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Purpose : characterises one 3-input combinational cell. On start it walks the eight input
//           vectors 000..111, holds each for SETTLE_CYCLES+1 cycles, samples the cell output
//           at the end of each window into signature[7 - idx] and flags signature == EXPECTED.
// Ports   : i_clk   - clock, rising edge
//           i_reset - synchronous active-high reset
//           io_bus  - truth_table_sweeper_if.slave (start/busy/done, cell drive/response,
//                     signature, match, unstable)
// Options : define TRUTH_TABLE_SWEEPER_STABLE_CHECK_EN to also sample the cell one cycle
//           before the final sample of each window; a disagreement sets the sticky
//           unstable flag and forces match low. Undefined: unstable is tied to 0.
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  EXPECTED      = 8'hEF
) (
  input logic                  i_clk,
  input logic                  i_reset,
  truth_table_sweeper_if.slave io_bus
);

  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {StIdle, StDrive, StFinish} state_e;

  state_e     r_state;
  logic [2:0] r_idx;
  logic [3:0] r_cnt;
  logic [7:0] r_sig;
  logic       r_busy;
  logic       r_done;
  logic       r_match;

  logic       w_last_cyc;
  logic [7:0] w_sig_next;
  logic       w_unstable_next;
  logic       w_match_next;

  assign w_last_cyc = (r_cnt == SettleLast);

  // 7 - idx on a 3-bit index is its bitwise inverse.
  always_comb begin
    w_sig_next         = r_sig;
    w_sig_next[~r_idx] = io_bus.out;
  end

`ifdef TRUTH_TABLE_SWEEPER_STABLE_CHECK_EN
  localparam logic [3:0] SettleEarly = 4'(SETTLE_CYCLES - 1);

  logic r_early;
  logic r_unstable;

  // Only consumed on the window's final cycle, when r_early holds the previous cycle's sample.
  assign w_unstable_next = r_unstable | (io_bus.out != r_early);
  assign io_bus.unstable = r_unstable;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_early    <= 1'b0;
      r_unstable <= 1'b0;
    end else begin
      if (r_state == StIdle && io_bus.start) begin
        r_unstable <= 1'b0;
      end
      if (r_state == StDrive) begin
        if (r_cnt == SettleEarly) r_early <= io_bus.out;
        if (w_last_cyc) r_unstable <= w_unstable_next;
      end
    end
  end
`else
  assign w_unstable_next = 1'b0;
  assign io_bus.unstable = 1'b0;
`endif

  // Match must already reflect the last bit in the cycle done is high.
  assign w_match_next = (w_sig_next == EXPECTED) && !w_unstable_next;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_idx   <= 3'd0;
      r_cnt   <= 4'd0;
      r_sig   <= 8'h00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_match <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (io_bus.start) begin
            r_state <= StDrive;
            r_busy  <= 1'b1;
            r_idx   <= 3'd0;
            r_cnt   <= 4'd0;
            r_sig   <= 8'h00;
            r_match <= 1'b0;
          end
        end
        StDrive: begin
          if (w_last_cyc) begin
            r_sig <= w_sig_next;
            r_cnt <= 4'd0;
            r_idx <= r_idx + 3'd1;  // wraps to 000 after the last vector
            if (r_idx == 3'd7) begin
              r_state <= StFinish;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_match <= w_match_next;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        StFinish: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign io_bus.in1       = r_idx[2];
  assign io_bus.in2       = r_idx[1];
  assign io_bus.in3       = r_idx[0];
  assign io_bus.busy      = r_busy;
  assign io_bus.done      = r_done;
  assign io_bus.signature = r_sig;
  assign io_bus.match     = r_match;

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequencer that characterises one 3-input combinational logic cell, such as a wolfram-coded gate. On `start`, it drives all eight input vectors in order onto the cell's `in1`/`in2`/`in3` and waits a programmable settle time for each. It samples the cell's `out` and packs the results into an 8-bit hex signature using the same code convention as the cell name (e.g. 0xEF). It sits between the test/configuration controller and a single truth-table cell, and compares the measured signature against an expected code.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: hold cycles per vector before sampling. Legal range 1..15.
- `EXPECTED`, default 8'hEF: reference signature for the `match` flag.

Ports:
- `clk` input 1: single clock, all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: request a sweep; honoured only in IDLE.
- `busy` output 1: high while a sweep is in progress.
- `done` output 1: one-cycle pulse when a sweep completes.
- `in1`, `in2`, `in3` output 1 each: drive to the cell under test; `{in1,in2,in3}` = current vector index.
- `out` input 1: cell response.
- `signature` output 8: measured code; held until the next sweep starts.
- `match` output 1: `signature == EXPECTED`; valid from `done` until the next start.
- `unstable` output 1: stability error flag (see Configuration).

## Operation
- States: IDLE, DRIVE, FINISH.
- IDLE:
  - `{in1,in2,in3}`=3'b000, `busy`=0.
  - `start`=1 → DRIVE, vector index=0, settle count=0, `signature` cleared to 0, `match`=0, `unstable`=0.
- DRIVE:
  - Each vector window lasts SETTLE_CYCLES+1 cycles, numbered 0..SETTLE_CYCLES.
  - Inputs are stable for the whole window.
  - `out` is sampled at the edge ending window cycle SETTLE_CYCLES.
  - The sample is written to `signature[7 - idx]`, where idx={in1,in2,in3}. With this mapping, vector 000 → bit7 and vector 011 → bit4, so a cell that is 0 only at 011 reads 0xEF.
  - After the sample, idx increments. After the idx=7 sample → FINISH (idx wraps to 0, inputs return to 000).
- FINISH:
  - One cycle.
  - `done`=1, `match` updated from the final signature.
  - → IDLE.
- `start` in DRIVE or FINISH is ignored; it is not queued.
- `start` held high continuously starts a new sweep on the first IDLE cycle after FINISH.
- Reset values (any state, including mid-sweep): IDLE, inputs 000, `busy`=0, `done`=0, `signature`=8'h00, `match`=0, `unstable`=0, counters 0. A partial signature is discarded.

## Timing
- Start edge: `start` sampled high in IDLE at edge T → `busy`=1 and vector 000 driven from T.
- Total sweep: 8×(SETTLE_CYCLES+1) DRIVE cycles, then the FINISH cycle. `done` is high in cycle T+8×(SETTLE_CYCLES+1), e.g. T+24 for SETTLE_CYCLES=2.
- `busy` deasserts in the same cycle `done` asserts.
- Inputs change only on window boundaries, so a registered cell plus combinational logic has SETTLE_CYCLES cycles to resolve.
- `signature` bits update one per window; the value is only meaningful once `done` has pulsed.

## Configuration
- Macro: `TRUTH_TABLE_SWEEPER_STABLE_CHECK_EN`.
- Defined:
  - `out` is also captured at window cycle SETTLE_CYCLES−1 and compared with the final sample.
  - Any mismatch sets `unstable`=1, sticky until the next start or reset.
  - `match` is forced 0 when `unstable`=1.
- Undefined: single sample per window; `unstable` tied to 0; no extra register.

## Test plan
- Cell model m0xEF (0 only at 011), SETTLE_CYCLES=2, pulse `start` → `done` at T+24, `signature`=8'hEF, `match`=1, `busy` high for cycles T..T+23.
- Cell model constant 1 → `signature`=8'hFF, `match`=0; cell = `in1&in2&in3` → 8'h01.
- Pulse `start` again at T+5 mid-sweep → ignored: exactly one `done`, at T+24, with correct signature.
- Assert `reset` at T+10 → next cycle `busy`=0, inputs 000, `signature`=0. A later `start` yields a full, correct 0xEF sweep.
- Hold `start` high continuously → back-to-back sweeps with one idle cycle between FINISH and the next DRIVE; `done` every 26 cycles.
- With the macro defined, cell output toggles within window 3 (index 011) → `unstable`=1, `match`=0. Without the macro, same stimulus → `unstable`=0.
